// File: rtl/edge_detection.sv
// Two-layer 64x64 edge detector: 3x3 blur (median/Gaussian) into layer-1 memory,
// then Sobel magnitude with binarization into layer-2 memory.
module edge_detection (
   input  logic        clk,
   input  logic        reset,
   output logic        busy,
   input  logic        switch,
   input  logic [7:0]  threshold,
   output logic [11:0] iaddr_1,
   output logic [11:0] iaddr_2,
   output logic [11:0] iaddr_3,
   output logic [11:0] iaddr_4,
   output logic [11:0] iaddr_5,
   output logic [11:0] iaddr_6,
   output logic [11:0] iaddr_7,
   output logic [11:0] iaddr_8,
   output logic [11:0] iaddr_9,
   input  logic [7:0]  idata_1,
   input  logic [7:0]  idata_2,
   input  logic [7:0]  idata_3,
   input  logic [7:0]  idata_4,
   input  logic [7:0]  idata_5,
   input  logic [7:0]  idata_6,
   input  logic [7:0]  idata_7,
   input  logic [7:0]  idata_8,
   input  logic [7:0]  idata_9,
   output logic        cwr,
   output logic [11:0] caddr_wr,
   output logic [7:0]  cdata_wr,
   output logic        crd,
   output logic [11:0] caddr_rd_1,
   output logic [11:0] caddr_rd_2,
   output logic [11:0] caddr_rd_3,
   output logic [11:0] caddr_rd_4,
   output logic [11:0] caddr_rd_5,
   output logic [11:0] caddr_rd_6,
   output logic [11:0] caddr_rd_7,
   output logic [11:0] caddr_rd_8,
   output logic [11:0] caddr_rd_9,
   input  logic [7:0]  cdata_rd_1,
   input  logic [7:0]  cdata_rd_2,
   input  logic [7:0]  cdata_rd_3,
   input  logic [7:0]  cdata_rd_4,
   input  logic [7:0]  cdata_rd_5,
   input  logic [7:0]  cdata_rd_6,
   input  logic [7:0]  cdata_rd_7,
   input  logic [7:0]  cdata_rd_8,
   input  logic [7:0]  cdata_rd_9,
   output logic [2:0]  csel
);
   localparam int unsigned PW   = 8;
   localparam int unsigned AW   = 12;
   localparam int unsigned NWIN = 9;
   localparam logic [AW-1:0] LAST = 12'd4095;

   typedef enum logic [1:0] {S_IDLE, S_L1, S_L2, S_DONE} state_t;
   typedef enum logic [1:0] {PH_A, PH_B, PH_F} phase_t;

   // Window position k (0..8, row-major) around pixel p; off-image rows/cols wrap in range.
   function automatic logic [AW-1:0] win_addr(input logic [AW-1:0] p, input int k);
      logic [5:0] r;
      logic [5:0] c;
      r = p[11:6] + 6'(k / 3) - 6'd1;
      c = p[5:0] + 6'(k % 3) - 6'd1;
      return {r, c};
   endfunction

   function automatic logic win_ok(input logic [AW-1:0] p, input int k);
      int r;
      int c;
      r = int'(p[11:6]) + k / 3 - 1;
      c = int'(p[5:0]) + k % 3 - 1;
      return (r >= 0) && (r < 64) && (c >= 0) && (c < 64);
   endfunction

   state_t        r_state;
   phase_t        r_ph;
   logic [AW:0]   r_ic;
   logic          r_v0, r_v1;
   logic [AW-1:0] r_p0, r_p1, r_l2p;
   logic          r_sw;
   logic [PW-1:0] r_thr;
   logic [PW-1:0] r_win     [NWIN];
   logic [AW-1:0] r_iaddr   [NWIN];
   logic [AW-1:0] r_caddr_rd[NWIN];

   logic [PW-1:0] w_idata[NWIN];
   logic [PW-1:0] w_cdata[NWIN];
   logic [PW-1:0] w_cwin [NWIN];
   logic [AW-1:0] w_gsum, w_gx, w_gy, w_ax, w_ay, w_mag;
   logic [PW-1:0] w_med, w_blur, w_bin;
   logic [3:0]    w_cnt;

   assign w_idata = '{idata_1, idata_2, idata_3, idata_4, idata_5, idata_6, idata_7, idata_8, idata_9};
   assign w_cdata = '{cdata_rd_1, cdata_rd_2, cdata_rd_3, cdata_rd_4, cdata_rd_5,
                      cdata_rd_6, cdata_rd_7, cdata_rd_8, cdata_rd_9};

   assign iaddr_1 = r_iaddr[0];
   assign iaddr_2 = r_iaddr[1];
   assign iaddr_3 = r_iaddr[2];
   assign iaddr_4 = r_iaddr[3];
   assign iaddr_5 = r_iaddr[4];
   assign iaddr_6 = r_iaddr[5];
   assign iaddr_7 = r_iaddr[6];
   assign iaddr_8 = r_iaddr[7];
   assign iaddr_9 = r_iaddr[8];
   assign caddr_rd_1 = r_caddr_rd[0];
   assign caddr_rd_2 = r_caddr_rd[1];
   assign caddr_rd_3 = r_caddr_rd[2];
   assign caddr_rd_4 = r_caddr_rd[3];
   assign caddr_rd_5 = r_caddr_rd[4];
   assign caddr_rd_6 = r_caddr_rd[5];
   assign caddr_rd_7 = r_caddr_rd[6];
   assign caddr_rd_8 = r_caddr_rd[7];
   assign caddr_rd_9 = r_caddr_rd[8];

   // Median by rank: element whose stable rank (ties broken by index) is 4.
   always_comb begin
      w_med = '0;
      w_cnt = '0;
      for (int i = 0; i < int'(NWIN); i++) begin
         w_cnt = '0;
         for (int j = 0; j < int'(NWIN); j++) begin
            if ((j != i) && ((r_win[j] < r_win[i]) || ((r_win[j] == r_win[i]) && (j < i))))
               w_cnt = w_cnt + 4'd1;
         end
         if (w_cnt == 4'd4) w_med = r_win[i];
      end
   end

   always_comb begin
      w_gsum = 12'(r_win[0]) + (12'(r_win[1]) << 1) + 12'(r_win[2])
             + (12'(r_win[3]) << 1) + (12'(r_win[4]) << 2) + (12'(r_win[5]) << 1)
             + 12'(r_win[6]) + (12'(r_win[7]) << 1) + 12'(r_win[8]);
      w_blur = r_sw ? 8'(w_gsum >> 4) : w_med;
   end

   // Sobel on the layer-1 window arriving at the end of read cycle A.
   always_comb begin
      for (int k = 0; k < int'(NWIN); k++)
         w_cwin[k] = win_ok(r_l2p, k) ? w_cdata[k] : '0;
      w_gx = (12'(w_cwin[2]) + (12'(w_cwin[5]) << 1) + 12'(w_cwin[8]))
           - (12'(w_cwin[0]) + (12'(w_cwin[3]) << 1) + 12'(w_cwin[6]));
      w_gy = (12'(w_cwin[6]) + (12'(w_cwin[7]) << 1) + 12'(w_cwin[8]))
           - (12'(w_cwin[0]) + (12'(w_cwin[1]) << 1) + 12'(w_cwin[2]));
      w_ax  = w_gx[11] ? 12'(-w_gx) : w_gx;
      w_ay  = w_gy[11] ? 12'(-w_gy) : w_gy;
      w_mag = w_ax + w_ay;
      w_bin = (w_mag > 12'(r_thr)) ? 8'hFF : 8'h00;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_ph     <= PH_A;
         r_ic     <= '0;
         r_v0     <= 1'b0;
         r_v1     <= 1'b0;
         r_p0     <= '0;
         r_p1     <= '0;
         r_l2p    <= '0;
         r_sw     <= 1'b0;
         r_thr    <= '0;
         busy     <= 1'b0;
         cwr      <= 1'b0;
         crd      <= 1'b0;
         csel     <= 3'b000;
         caddr_wr <= '0;
         cdata_wr <= '0;
         for (int k = 0; k < int'(NWIN); k++) begin
            r_win[k]      <= '0;
            r_iaddr[k]    <= '0;
            r_caddr_rd[k] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_L1;
               busy    <= 1'b1;
               r_sw    <= switch;
               r_thr   <= threshold;
            end
            S_L1: begin
               // Issue -> sample masked window -> compute and write: 3-stage pipeline.
               if (!r_ic[AW]) begin
                  for (int k = 0; k < int'(NWIN); k++) r_iaddr[k] <= win_addr(r_ic[AW-1:0], k);
                  r_v0 <= 1'b1;
                  r_p0 <= r_ic[AW-1:0];
                  r_ic <= r_ic + 13'd1;
               end else begin
                  r_v0 <= 1'b0;
               end
               r_v1 <= r_v0;
               r_p1 <= r_p0;
               for (int k = 0; k < int'(NWIN); k++) r_win[k] <= win_ok(r_p0, k) ? w_idata[k] : '0;
               cwr      <= r_v1;
               csel     <= r_v1 ? 3'b001 : 3'b000;
               caddr_wr <= r_p1;
               cdata_wr <= w_blur;
               if (cwr && (caddr_wr == LAST)) begin
                  r_state <= S_L2;
                  r_ph    <= PH_A;
                  cwr     <= 1'b0;
                  csel    <= 3'b000;
               end
            end
            S_L2: begin
               case (r_ph)
                  PH_A: begin
                     crd  <= 1'b1;
                     cwr  <= 1'b0;
                     csel <= 3'b001;
                     for (int k = 0; k < int'(NWIN); k++) r_caddr_rd[k] <= win_addr(r_l2p, k);
                     r_ph <= PH_B;
                  end
                  PH_B: begin
                     crd      <= 1'b0;
                     cwr      <= 1'b1;
                     csel     <= 3'b010;
                     caddr_wr <= r_l2p;
                     cdata_wr <= w_bin;
                     if (r_l2p == LAST) begin
                        r_ph <= PH_F;
                     end else begin
                        r_l2p <= r_l2p + 12'd1;
                        r_ph  <= PH_A;
                     end
                  end
                  default: begin
                     cwr     <= 1'b0;
                     crd     <= 1'b0;
                     csel    <= 3'b000;
                     r_state <= S_DONE;
                  end
               endcase
            end
            default: begin
               busy <= 1'b0;
               cwr  <= 1'b0;
               crd  <= 1'b0;
               csel <= 3'b000;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_edge_detection.sv
// Scoreboarded bench for edge_detection: memory models, behavioural reference, protocol monitor.
module tb_edge_detection;
   localparam int NPIX = 4096;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        busy;
   logic        switch = 1'b0;
   logic [7:0]  threshold = '0;
   logic [11:0] iaddr [9];
   logic [7:0]  idata [9];
   logic        cwr, crd;
   logic [11:0] caddr_wr;
   logic [7:0]  cdata_wr;
   logic [11:0] caddr_rd [9];
   logic [7:0]  cdata_rd [9];
   logic [2:0]  csel;

   logic [7:0] img  [NPIX];
   logic [7:0] mem1 [NPIX];
   logic [7:0] mem2 [NPIX];
   int         e1   [NPIX];
   exp_t       q1[$], q2[$];
   exp_t       m_e;

   int checks = 0, errors = 0;
   int cyc = 0, nw1 = 0, nw2 = 0, rises = 0, falls = 0, last_wr = 0;
   logic busy_q = 1'b0;

   always #5 clk = ~clk;

   edge_detection dut (
      .clk(clk), .reset(reset), .busy(busy), .switch(switch), .threshold(threshold),
      .iaddr_1(iaddr[0]), .iaddr_2(iaddr[1]), .iaddr_3(iaddr[2]), .iaddr_4(iaddr[3]), .iaddr_5(iaddr[4]),
      .iaddr_6(iaddr[5]), .iaddr_7(iaddr[6]), .iaddr_8(iaddr[7]), .iaddr_9(iaddr[8]),
      .idata_1(idata[0]), .idata_2(idata[1]), .idata_3(idata[2]), .idata_4(idata[3]), .idata_5(idata[4]),
      .idata_6(idata[5]), .idata_7(idata[6]), .idata_8(idata[7]), .idata_9(idata[8]),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
      .caddr_rd_1(caddr_rd[0]), .caddr_rd_2(caddr_rd[1]), .caddr_rd_3(caddr_rd[2]),
      .caddr_rd_4(caddr_rd[3]), .caddr_rd_5(caddr_rd[4]), .caddr_rd_6(caddr_rd[5]),
      .caddr_rd_7(caddr_rd[6]), .caddr_rd_8(caddr_rd[7]), .caddr_rd_9(caddr_rd[8]),
      .cdata_rd_1(cdata_rd[0]), .cdata_rd_2(cdata_rd[1]), .cdata_rd_3(cdata_rd[2]),
      .cdata_rd_4(cdata_rd[3]), .cdata_rd_5(cdata_rd[4]), .cdata_rd_6(cdata_rd[5]),
      .cdata_rd_7(cdata_rd[6]), .cdata_rd_8(cdata_rd[7]), .cdata_rd_9(cdata_rd[8]),
      .csel(csel)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Image ROM and layer-1 read port: data driven after the falling edge, junk when not serviced.
   always @(negedge clk) begin
      for (int k = 0; k < 9; k++) begin
         idata[k]    = (reset && busy) ? img[iaddr[k]] : 8'($urandom);
         cdata_rd[k] = (reset && crd && csel == 3'b001) ? mem1[caddr_rd[k]] : 8'($urandom);
      end
   end

   always @(posedge clk) begin
      if (reset && cwr) begin
         if (csel == 3'b001) mem1[caddr_wr] <= cdata_wr;
         else if (csel == 3'b010) mem2[caddr_wr] <= cdata_wr;
      end
   end

   // Monitor: protocol rules plus in-order scoreboard compare of every write.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         if (cwr && crd) check("strobe_overlap", 1, 0);
         if ((cwr || crd) && csel != 3'b001 && csel != 3'b010) check("csel_code", int'(csel), 1);
         if (cwr && csel == 3'b001) begin
            if (q1.size() == 0) check("l1_extra_write", 1, 0);
            else begin
               m_e = q1.pop_front();
               check("l1_addr", int'(caddr_wr), int'(m_e.addr));
               check("l1_data", int'(cdata_wr), int'(m_e.data));
            end
            nw1++;
            last_wr = cyc;
         end
         if (cwr && csel == 3'b010) begin
            if (nw2 == 0) check("l2_after_l1", nw1, NPIX);
            if (q2.size() == 0) check("l2_extra_write", 1, 0);
            else begin
               m_e = q2.pop_front();
               check("l2_addr", int'(caddr_wr), int'(m_e.addr));
               check("l2_data", int'(cdata_wr), int'(m_e.data));
            end
            nw2++;
            last_wr = cyc;
         end
         if (busy && !busy_q) rises++;
         if (!busy && busy_q) begin
            falls++;
            check("busy_fall_gap", int'(cyc - last_wr >= 2), 1);
         end
      end
      busy_q = busy;
   end

   function automatic int pix(input int r, input int c);
      return (r < 0 || r > 63 || c < 0 || c > 63) ? 0 : int'(img[r * 64 + c]);
   endfunction

   function automatic int l1v(input int r, input int c);
      return (r < 0 || r > 63 || c < 0 || c > 63) ? 0 : e1[r * 64 + c];
   endfunction

   // Reference: blur by weighted sum or sorted-window median, then Sobel L1 magnitude vs threshold.
   task automatic build_model(input bit sw, input int thr);
      int v[9];
      int s, n, t, gx, gy, mag;
      q1.delete();
      q2.delete();
      for (int p = 0; p < NPIX; p++) begin
         s = 0;
         n = 0;
         for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
               s += (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1) * pix(p / 64 + dr, p % 64 + dc);
               v[n] = pix(p / 64 + dr, p % 64 + dc);
               n++;
            end
         for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
               t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
         e1[p] = sw ? s / 16 : v[4];
         q1.push_back('{12'(p), 8'(e1[p])});
      end
      for (int p = 0; p < NPIX; p++) begin
         gx = 0;
         gy = 0;
         for (int d = -1; d <= 1; d++) begin
            gx += (d == 0 ? 2 : 1) * (l1v(p / 64 + d, p % 64 + 1) - l1v(p / 64 + d, p % 64 - 1));
            gy += (d == 0 ? 2 : 1) * (l1v(p / 64 + 1, p % 64 + d) - l1v(p / 64 - 1, p % 64 + d));
         end
         mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
         q2.push_back('{12'(p), (mag > thr) ? 8'd255 : 8'd0});
      end
   endtask

   task automatic check_reset_vals(input string tag);
      int acc = 0;
      for (int k = 0; k < 9; k++) acc |= int'(iaddr[k]) | int'(caddr_rd[k]);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_cwr"}, int'(cwr), 0);
      check({tag, "_crd"}, int'(crd), 0);
      check({tag, "_csel"}, int'(csel), 0);
      check({tag, "_wr_addr_data"}, int'(caddr_wr) | int'(cdata_wr), 0);
      check({tag, "_rd_addrs"}, acc, 0);
   endtask

   task automatic start(input bit sw, input int thr);
      reset     = 1'b0;
      switch    = sw;
      threshold = 8'(thr);
      build_model(sw, thr);
      repeat (2) @(negedge clk);
      nw1 = 0; nw2 = 0; rises = 0; falls = 0;
      check_reset_vals("rst");
      #1 reset = 1'b1;
   endtask

   task automatic wait_done();
      bit fin = 1'b0;
      for (int i = 0; i < 13000 && !fin; i++) begin
         @(negedge clk);
         // Inputs change mid-run; the DUT must keep the values sampled at start.
         if (i == 3) begin
            switch    = ~switch;
            threshold = 8'($urandom);
         end
         if (falls > 0) fin = 1'b1;
      end
      check("run_finished", int'(fin), 1);
      repeat (3) @(negedge clk);
      check("l1_write_count", nw1, NPIX);
      check("l2_write_count", nw2, NPIX);
      check("busy_rises", rises, 1);
      check("busy_falls", falls, 1);
      check("queues_drained", q1.size() + q2.size(), 0);
      check("done_idle", int'(busy) | int'(cwr) | int'(crd), 0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int p = 0; p < NPIX; p++) begin
         mem1[p] = '0;
         mem2[p] = '0;
         img[p]  = 8'($urandom);
      end

      start(1'b1, 56);
      wait_done();

      for (int p = 0; p < NPIX; p++) img[p] = 8'd100;
      start(1'b1, int'($urandom_range(0, 255)));
      wait_done();
      check("gauss_corner_tl", int'(mem1[0]), 56);
      check("gauss_corner_br", int'(mem1[4095]), 56);
      check("gauss_border_top", int'(mem1[5]), 75);
      check("gauss_border_left", int'(mem1[640]), 75);
      check("gauss_interior", int'(mem1[65]), 100);

      start(1'b0, int'($urandom_range(0, 255)));
      wait_done();
      check("median_corner_tr", int'(mem1[63]), 0);
      check("median_corner_bl", int'(mem1[4032]), 0);
      check("median_border_right", int'(mem1[127]), 100);
      check("median_interior", int'(mem1[2080]), 100);

      for (int p = 0; p < NPIX; p++) img[p] = 8'd0;
      start(1'($urandom), 0);
      wait_done();

      // Abort in the middle of layer 2, then rerun from scratch.
      for (int p = 0; p < NPIX; p++) img[p] = 8'($urandom);
      begin
         bit hit = 1'b0;
         int thr = int'($urandom_range(10, 200));
         start(1'b0, thr);
         for (int i = 0; i < 6000 && !hit; i++) begin
            @(negedge clk);
            if (nw2 >= 300) hit = 1'b1;
         end
         check("reached_layer2", int'(hit), 1);
         #2 reset = 1'b0;
         #1 check_reset_vals("abort");
         start(1'b0, thr);
         wait_done();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
